pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It drives the load enables and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves three conditions:
- Read-after-write hazards, using a destination-register scoreboard, because the datapath has no forwarding.
- Taken-branch redirection.
- Multi-cycle data-memory accesses, via a req/ack handshake.

It also keeps saturating stall and flush counters for bring-up.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a five-stage MIPS pipeline without forwarding.
// Handles RAW interlocks (destination scoreboard), taken-branch flushes and slow data-memory waits.
module pipeline_hazard_ctrl #(
    parameter int WB_DEPTH    = 3,
    parameter int BR_SHADOW   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reg_write,
    input  logic [4:0]  id_dest,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0]  SHADOW  = 2'(BR_SHADOW);
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [1:0]          r_shadow;
    logic [WB_DEPTH-1:0] r_sb_valid;
    logic [4:0]          r_sb_dest [WB_DEPTH];
    logic [15:0]         r_stall_cnt;
    logic [15:0]         r_flush_cnt;
    logic [15:0]         r_wait_cnt;
    logic                r_mem_err;

    logic w_hit_rs;
    logic w_hit_rt;
    logic w_raw;
    logic w_freeze;
    logic w_flush;
    logic w_stall;
    logic w_issue;

    // A source matches if any in-flight writer (EX..WB) targets it; r0 never matches.
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (r_sb_valid[i] && (r_sb_dest[i] == id_rs)) w_hit_rs = 1'b1;
            if (r_sb_valid[i] && (r_sb_dest[i] == id_rt)) w_hit_rt = 1'b1;
        end
    end

    assign w_raw    = id_valid &&
                      ((id_uses_rs && (id_rs != 5'd0) && w_hit_rs) ||
                       (id_uses_rt && (id_rt != 5'd0) && w_hit_rt));
    assign w_freeze = mem_req && !mem_ack;
    // An unfrozen MEMWAIT cycle behaves like RUN, so a branch parked in EX is not lost.
    assign w_flush  = !w_freeze && ((r_state == ST_FLUSH) || ex_branch_taken);
    assign w_stall  = !w_freeze && !w_flush && w_raw;
    assign w_issue  = !w_freeze && !w_flush && !w_raw &&
                      id_valid && id_reg_write && (id_dest != 5'd0);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
        end else if (w_freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Scoreboard: shifts with the pipeline, holds while memory freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_valid <= '0;
            for (int i = 0; i < WB_DEPTH; i++) r_sb_dest[i] <= 5'd0;
        end else if (!w_freeze) begin
            for (int i = WB_DEPTH - 1; i > 0; i--) begin
                r_sb_valid[i] <= r_sb_valid[i-1];
                r_sb_dest[i]  <= r_sb_dest[i-1];
            end
            r_sb_valid[0] <= w_issue;
            r_sb_dest[0]  <= w_issue ? id_dest : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_shadow <= 2'd0;
        end else if (w_freeze) begin
            if (r_state != ST_FLUSH) r_state <= ST_MEMWAIT;
        end else if (r_state == ST_FLUSH) begin
            if (r_shadow <= 2'd1) r_state <= ST_RUN;
            else                  r_shadow <= r_shadow - 2'd1;
        end else if (ex_branch_taken && (SHADOW != 2'd0)) begin
            r_state  <= ST_FLUSH;
            r_shadow <= SHADOW;
        end else begin
            r_state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    // Timeout counts consecutive frozen cycles, starting with the cycle the freeze begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
        end else if (w_freeze) begin
            if (r_wait_cnt != 16'hFFFF) r_wait_cnt <= r_wait_cnt + 16'd1;
            if (r_wait_cnt >= TO_LAST)  r_mem_err  <= 1'b1;
        end else begin
            r_wait_cnt <= 16'd0;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: per-cycle expected control vectors queued and compared.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] C_NORM  = 6'b110011;
    localparam logic [5:0] C_STALL = 6'b000111;
    localparam logic [5:0] C_FLUSH = 6'b111111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_RST   = 6'b001100;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic [4:0] dest;
        logic       br;
        logic       req;
        logic       ack;
        logic [8:0] exp;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_reg_write;
    logic [4:0]  id_dest;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_en;
    logic        memwb_en;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        mem_err;

    logic [8:0]  w_obs;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_v;
    int          checks;
    int          errors;

    pipeline_hazard_ctrl #(.WB_DEPTH(3), .BR_SHADOW(1), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_dest(id_dest),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    assign w_obs = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, state, mem_err};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] e(input logic [5:0] c, input logic [1:0] st, input logic err);
        return {c, st, err};
    endfunction

    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic rw,
                                 input logic [4:0] dest, input logic br, input logic req,
                                 input logic ack, input logic [8:0] exp);
        stim_t s;
        s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.rw = rw;
        s.dest = dest; s.br = br; s.req = req; s.ack = ack; s.exp = exp;
        return s;
    endfunction

    function automatic stim_t idle(input logic br, input logic req, input logic ack,
                                   input logic [8:0] exp);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, br, req, ack, exp);
    endfunction

    // driver
    task automatic apply(input stim_t s);
        id_valid        = s.v;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        id_reg_write    = s.rw;
        id_dest         = s.dest;
        ex_branch_taken = s.br;
        mem_req         = s.req;
        mem_ack         = s.ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(mk(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1,
                     1'b1, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 9'd0));
            exp_q.push_back(e(C_RST, 2'd0, 1'b0));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            checks++;
            if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
            end
        end
        apply(idle(1'b0, 1'b0, 1'b0, 9'd0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_independent();
        stim_t sq[$];
        for (int k = 0; k < 8; k++)
            sq.push_back(mk(1'b1, 5'($urandom_range(1, 15)), 5'($urandom_range(1, 15)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                            5'($urandom_range(16, 31)), 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL independent[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL independent_stall_cnt got %0d exp 0", stall_cnt);
        end
    endtask

    task automatic test_raw();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(mk(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, e(C_STALL, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(mk(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, e(C_STALL, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL raw[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== 16'd6) begin
            errors++;
            $display("FAIL raw_stall_cnt got %0d exp 6", stall_cnt);
        end
    endtask

    task automatic test_r0();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL r0_unused[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== 16'd6) begin
            errors++;
            $display("FAIL r0_stall_cnt got %0d exp 6", stall_cnt);
        end
    endtask

    task automatic test_branch();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, e(C_FLUSH, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, e(C_FLUSH, 2'd1, 1'b0)));
        sq.push_back(mk(1'b1, 5'd11, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        repeat (3) sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL branch[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd6) begin
            errors++;
            $display("FAIL branch_counters flush/stall got %0d/%0d exp 2/6", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd0, 1'b0)));
        repeat (3) sq.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd2, 1'b0)));
        sq.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, e(C_STALL, 2'd2, 1'b0)));
        repeat (2) sq.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e(C_STALL, 2'd0, 1'b0)));
        sq.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL mem_wait[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            if (k == 4) begin
                checks++;
                if (stall_cnt !== 16'd6) begin
                    errors++;
                    $display("FAIL mem_wait_frozen_stall_cnt got %0d exp 6", stall_cnt);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_cnt !== 16'd9) begin
            errors++;
            $display("FAIL mem_wait_stall_cnt got %0d exp 9", stall_cnt);
        end
    endtask

    task automatic test_mem_branch();
        stim_t sq[$];
        sq.push_back(idle(1'b1, 1'b1, 1'b0, e(C_FRZ, 2'd0, 1'b0)));
        sq.push_back(idle(1'b1, 1'b1, 1'b0, e(C_FRZ, 2'd2, 1'b0)));
        sq.push_back(idle(1'b1, 1'b1, 1'b1, e(C_FLUSH, 2'd2, 1'b0)));
        sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_FLUSH, 2'd1, 1'b0)));
        sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        sq.push_back(idle(1'b1, 1'b0, 1'b0, e(C_FLUSH, 2'd0, 1'b0)));
        sq.push_back(idle(1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd1, 1'b0)));
        sq.push_back(idle(1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd1, 1'b0)));
        sq.push_back(idle(1'b0, 1'b1, 1'b1, e(C_FLUSH, 2'd1, 1'b0)));
        sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b0)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL mem_branch[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (flush_cnt !== 16'd6) begin
            errors++;
            $display("FAIL mem_branch_flush_cnt got %0d exp 6", flush_cnt);
        end
    endtask

    task automatic test_timeout_reset();
        stim_t sq[$];
        sq.push_back(idle(1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd0, 1'b0)));
        repeat (7) sq.push_back(idle(1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd2, 1'b0)));
        repeat (3) sq.push_back(idle(1'b0, 1'b1, 1'b0, e(C_FRZ, 2'd2, 1'b1)));
        sq.push_back(idle(1'b0, 1'b1, 1'b1, e(C_NORM, 2'd2, 1'b1)));
        sq.push_back(idle(1'b0, 1'b0, 1'b0, e(C_NORM, 2'd0, 1'b1)));
        foreach (sq[k]) begin
            apply(sq[k]);
            exp_q.push_back(sq[k].exp);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL timeout[%0d] got %b exp %b", k, w_obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        apply(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 9'd0));
        #2;
        rst_n = 1'b0;
        exp_q.push_back(e(C_RST, 2'd0, 1'b0));
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (w_obs !== exp_v) begin
            errors++;
            $display("FAIL midrun_reset got %b exp %b", w_obs, exp_v);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e(C_NORM, 2'd0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (w_obs !== exp_v) begin
            errors++;
            $display("FAIL after_reset got %b exp %b", w_obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        apply(idle(1'b0, 1'b0, 1'b0, 9'd0));
        #2;
        test_reset();
        test_independent();
        test_raw();
        test_r0();
        test_branch();
        test_mem_wait();
        test_mem_branch();
        test_timeout_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d entries exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
